// File: rtl/ifetch_queue.sv
// ifetch_queue: first-word-fall-through instruction fetch FIFO with single-cycle flush
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   in_inst,
  input  logic [31:0]   in_pc4,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_inst,
  output logic [31:0]   out_pc4,
  input  logic          out_ready,
  input  logic          flush,
  output logic [AW:0]   count
);
  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop;
  assign full      = count_q == (AW+1)'(DEPTH);
  assign empty     = count_q == '0;
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;
  assign {out_inst, out_pc4} = empty ? 64'h0 : mem_q[rd_ptr_q];
  // Pointers wrap naturally at DEPTH; flush overrides any push/pop
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // Control state, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // Storage is never cleared; a flushed push is not written
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= {in_inst, in_pc4};
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scoreboard bench for the instruction fetch queue
module tb_ifetch_queue;
  localparam int DEPTH = 4;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, out_ready = 0, flush = 0;
  logic [31:0] in_inst = 0, in_pc4 = 0;
  logic        in_ready, out_valid;
  logic [31:0] out_inst, out_pc4;
  logic [2:0]  count;
  logic [63:0] exp_q [$];
  int errors = 0, checks = 0;

  ifetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_pc4(in_pc4),
    .in_ready(in_ready), .out_valid(out_valid), .out_inst(out_inst), .out_pc4(out_pc4),
    .out_ready(out_ready), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [63:0] head;
    head = exp_q.size() > 0 ? exp_q[0] : 64'h0;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_q.size() < DEPTH));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(exp_q.size() > 0));
    chk({tag, ".head"}, {out_inst, out_pc4}, head);
    chk({tag, ".count"}, 64'(count), 64'(exp_q.size()));
  endtask

  // one cycle: drive, check combinational view, update model, cross the edge
  task automatic cyc(input string tag, input logic v, input logic [31:0] i, input logic [31:0] p,
                     input logic r, input logic f);
    logic push, pop;
    in_valid = v; in_inst = i; in_pc4 = p; out_ready = r; flush = f;
    #1;
    check_state(tag);
    push = v && exp_q.size() < DEPTH;
    pop  = r && exp_q.size() > 0;
    if (f) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back({i, p});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    check_state("reset");
    #1 rst = 0;
    @(posedge clk); #1;
    // 2: single push becomes visible after the edge
    cyc("t2push", 1, 32'h2008_0005, 32'h4, 0, 0);
    in_valid = 0; #1;
    chk("t2.out_inst", 64'(out_inst), 64'h2008_0005);
    chk("t2.out_pc4", 64'(out_pc4), 64'h4);
    chk("t2.count", 64'(count), 64'd1);
    // 1: async reset with 3 entries takes effect without an edge
    cyc("t1a", 1, 32'h1111_0001, 32'h8, 0, 0);
    cyc("t1b", 1, 32'h1111_0002, 32'hC, 0, 0);
    in_valid = 0;
    chk("t1.pre_count", 64'(count), 64'd3);
    rst = 1; #1;
    exp_q.delete();
    chk("t1.count", 64'(count), 64'd0);
    chk("t1.out_valid", 64'(out_valid), 64'd0);
    chk("t1.out_inst", 64'(out_inst), 64'd0);
    check_state("t1");
    @(posedge clk); #1 rst = 0;
    // 3: fill, reject a 5th, drain in order
    for (int k = 0; k < 4; k++) cyc("t3fill", 1, 32'hA000_0000 + k, 32'h100 + 4 * k, 0, 0);
    cyc("t3over", 1, 32'hBAD0_0005, 32'h200, 0, 0);
    chk("t3.count", 64'(count), 64'd4);
    chk("t3.in_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 4; k++) cyc("t3drain", 0, 0, 0, 1, 0);
    cyc("t3empty", 0, 0, 0, 1, 0);
    chk("t3.out_valid", 64'(out_valid), 64'd0);
    // 4: full with push+pop drops the push
    for (int k = 0; k < 4; k++) cyc("t4fill", 1, 32'hC000_0000 + k, 32'h300 + 4 * k, 0, 0);
    cyc("t4pp", 1, 32'hBAD0_0004, 32'h400, 1, 0);
    chk("t4.count", 64'(count), 64'd3);
    chk("t4.in_ready", 64'(in_ready), 64'd1);
    // 5: steady push+pop at count=2 across pointer wrap
    cyc("t5pop", 0, 0, 0, 1, 0);
    for (int k = 0; k < 10; k++) cyc("t5pp", 1, $urandom, $urandom, 1, 0);
    chk("t5.count", 64'(count), 64'd2);
    // 6: flush overrides push and pop
    cyc("t6push", 1, 32'hD000_0001, 32'h500, 0, 0);
    chk("t6.pre_count", 64'(count), 64'd3);
    cyc("t6flush", 1, 32'hBAD0_0006, 32'h600, 1, 1);
    chk("t6.count", 64'(count), 64'd0);
    chk("t6.out_valid", 64'(out_valid), 64'd0);
    chk("t6.out_inst", 64'(out_inst), 64'd0);
    cyc("t6idle", 0, 0, 0, 1, 0);
    cyc("t6after", 1, 32'hE000_0001, 32'h700, 0, 0);
    cyc("t6read", 0, 0, 0, 1, 0);
    check_state("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
